// File: rtl/seq_match_scheduler.sv
// Round-robin arbiter that time-shares one bit-serial 1011 detector among NREQ requesters.
// Each granted word is cleared into the detector, shifted MSB-first, and its hit count is returned.
module seq_match_scheduler #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int NBITS = 8,
  parameter int CW    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [CW-1:0]         match_cnt,
  output logic                  hit,
  output logic                  det_bit,
  output logic                  det_reset,
  input  logic                  det_seen
);
  localparam int BCW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_SHIFT, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   rr_ptr, gnt, sel;
  logic             found;
  logic [NBITS-1:0] shreg, word_sel;
  logic [BCW-1:0]   bitcnt;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             sample;

  // Two priority passes: first requesters at/after rr_ptr, then the wrapped-around ones.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int j = 0; j < NREQ; j++)
      if (!found && req[j] && IDW'(j) >= rr_ptr) begin
        found = 1'b1;
        sel   = IDW'(j);
      end
    for (int j = 0; j < NREQ; j++)
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = IDW'(j);
      end
  end

  always_comb begin
    word_sel = '0;
    for (int k = 0; k < NREQ; k++)
      if (sel == IDW'(k)) word_sel = req_data[k*NBITS +: NBITS];
  end

  // det_seen lags det_bit by one cycle, so the first SHIFT sample still shows the CLR state.
  assign sample = (state == S_SHIFT && bitcnt != '0) || state == S_DRAIN;
  assign cnt_nx = (sample && det_seen && cnt != CMAX) ? cnt + CW'(1) : cnt;

  always_ff @(posedge clk)
    if (reset) state <= S_IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    det_bit   = 1'b0;
    det_reset = reset;
    case (state)
      S_IDLE:  if (found) state_nx = S_CLR;
      S_CLR: begin
        busy      = 1'b1;
        det_reset = 1'b1;
        state_nx  = S_SHIFT;
      end
      S_SHIFT: begin
        busy    = 1'b1;
        det_bit = shreg[NBITS-1];
        if (bitcnt == BCW'(NBITS - 1)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign ack = done ? (NREQ'(1) << gnt) : '0;

  always_ff @(posedge clk)
    if (reset) begin
      rr_ptr    <= '0;
      gnt       <= '0;
      shreg     <= '0;
      bitcnt    <= '0;
      cnt       <= '0;
      done_id   <= '0;
      match_cnt <= '0;
      hit       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (found) begin
          shreg  <= word_sel;
          gnt    <= sel;
          cnt    <= '0;
          bitcnt <= '0;
        end
        S_SHIFT: begin
          shreg  <= shreg << 1;
          bitcnt <= bitcnt + BCW'(1);
          cnt    <= cnt_nx;
        end
        // Results land at the end of DRAIN so they are valid alongside done.
        S_DRAIN: begin
          cnt       <= cnt_nx;
          done_id   <= gnt;
          match_cnt <= cnt_nx;
          hit       <= (cnt_nx != '0);
        end
        S_DONE: rr_ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
        default: ;
      endcase
    end
endmodule
